// File: rtl/pdp8_intctl.sv
// PDP-8 interrupt / IOT-skip controller: merges device lines, owns ION with its one-instruction delay.
// Optional INTCTL_MASK_EN adds a software-loadable interrupt mask (IOT 6004 read, 6005 load).
module pdp8_intctl #(
    parameter int NDEV  = 8,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic              iot,
    input  logic [11:0]       mb,
    input  logic [5:0]        io_select,
    input  logic [11:0]       ac,
    input  logic [NDEV-1:0]   dev_interrupt,
    input  logic [NDEV-1:0]   dev_selected,
    input  logic [NDEV-1:0]   dev_skip,
    input  logic              int_ack,
    output logic              io_selected,
    output logic              io_skip,
    output logic [11:0]       io_data_out,
    output logic              interrupt_req,
    output logic              ion,
    output logic [IDX_W-1:0]  int_src
);

    localparam logic [3:0] ST_F1 = 4'd1;
    localparam logic [3:0] ST_F3 = 4'd3;

    logic            ion_q, ion_d;
    logic            ion_delay_q, ion_delay_d;
    logic [1:0]      dly_cnt_q, dly_cnt_d;
    logic [NDEV-1:0] mask;
    logic [NDEV-1:0] pend;
    logic            any_pend;
    logic            own_win;
    logic [2:0]      fn;
    logic            own_sel;
    logic            own_skip;
    logic [11:0]     data_out;
    logic [IDX_W-1:0] src;

    // Bits of mb/ac that only the decode or the optional feature look at.
    logic unused_bits;
    assign unused_bits = ^{ac, mb[11:3]};

`ifdef INTCTL_MASK_EN
    logic [NDEV-1:0] mask_q, mask_d;
    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    always_comb begin
        pend      = dev_interrupt & mask;
        any_pend  = |pend;
        own_win   = (state == ST_F1) && iot && (io_select == 6'o00);
        fn        = mb[2:0];
        own_sel   = 1'b0;
        own_skip  = 1'b0;
        data_out  = '0;
        ion_d       = ion_q;
        ion_delay_d = ion_delay_q;
        dly_cnt_d   = dly_cnt_q;
`ifdef INTCTL_MASK_EN
        mask_d      = mask_q;
`endif
        if (own_win) begin
            case (fn)
                3'd0: begin
                    own_sel     = 1'b1;
                    own_skip    = ion_q;
                    ion_d       = 1'b0;
                    ion_delay_d = 1'b0;
                end
                3'd1: begin
                    own_sel     = 1'b1;
                    ion_d       = 1'b1;
                    ion_delay_d = 1'b1;
                    dly_cnt_d   = 2'd0;
                end
                3'd2: begin
                    own_sel     = 1'b1;
                    ion_d       = 1'b0;
                    ion_delay_d = 1'b0;
                end
                3'd3: begin
                    own_sel  = 1'b1;
                    own_skip = any_pend;
                end
`ifdef INTCTL_MASK_EN
                3'd4: begin
                    own_sel             = 1'b1;
                    data_out[NDEV-1:0]  = mask_q;
                end
                3'd5: begin
                    own_sel = 1'b1;
                    mask_d  = ac[NDEV-1:0];
                end
`endif
                default: ;
            endcase
        end
        // The delay expires on the second F3 after ION: the ION's own and the next instruction's.
        if ((state == ST_F3) && ion_delay_q) begin
            if (dly_cnt_q == 2'd1) begin
                ion_delay_d = 1'b0;
                dly_cnt_d   = 2'd0;
            end else begin
                dly_cnt_d = dly_cnt_q + 2'd1;
            end
        end
        if (int_ack) begin
            ion_d       = 1'b0;
            ion_delay_d = 1'b0;
        end
    end

    // Lowest index wins: scan downward so the last assignment is the highest priority.
    always_comb begin
        src = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (pend[i]) src = i[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ion_q       <= 1'b0;
            ion_delay_q <= 1'b0;
            dly_cnt_q   <= 2'd0;
        end else begin
            ion_q       <= ion_d;
            ion_delay_q <= ion_delay_d;
            dly_cnt_q   <= dly_cnt_d;
        end
    end

`ifdef INTCTL_MASK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask_q <= '1;
        else        mask_q <= mask_d;
    end
`endif

    assign io_selected   = reset & (own_sel | (|dev_selected));
    assign io_skip       = reset & (own_skip | (|(dev_skip & dev_selected)));
    assign io_data_out   = reset ? data_out : 12'd0;
    assign interrupt_req = ion_q & ~ion_delay_q & any_pend;
    assign ion           = ion_q;
    assign int_src       = reset ? src : '0;

endmodule

// File: tb/tb_pdp8_intctl.sv
// Self-checking bench for pdp8_intctl: directed scenarios followed by randomized instruction streams.
module tb_pdp8_intctl;

    localparam int NDEV  = 8;
    localparam int IDX_W = 4;
`ifdef INTCTL_MASK_EN
    localparam bit MASKEN = 1'b1;
`else
    localparam bit MASKEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       state = 4'd0;
    logic             iot = 1'b0;
    logic [11:0]      mb = 12'd0;
    logic [5:0]       io_select = 6'd0;
    logic [11:0]      ac = 12'd0;
    logic [NDEV-1:0]  dev_interrupt = '0;
    logic [NDEV-1:0]  dev_selected = '0;
    logic [NDEV-1:0]  dev_skip = '0;
    logic             int_ack = 1'b0;
    logic             io_selected;
    logic             io_skip;
    logic [11:0]      io_data_out;
    logic             interrupt_req;
    logic             ion;
    logic [IDX_W-1:0] int_src;

    int compared = 0;
    int mismatched = 0;

    // Reference model: ION flag, F3 cycles still to elapse before requests are honoured, mask.
    bit        m_ion;
    int        m_left;
    logic [7:0] m_mask;

    logic f1_skip, f1_sel;
    logic [11:0] f1_data;

    pdp8_intctl #(.NDEV(NDEV), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .state(state), .iot(iot), .mb(mb),
        .io_select(io_select), .ac(ac), .dev_interrupt(dev_interrupt),
        .dev_selected(dev_selected), .dev_skip(dev_skip), .int_ack(int_ack),
        .io_selected(io_selected), .io_skip(io_skip), .io_data_out(io_data_out),
        .interrupt_req(interrupt_req), .ion(ion), .int_src(int_src)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_ion  = 1'b0;
        m_left = 0;
        m_mask = 8'hFF;
    endtask

    // Drive one clk cycle's inputs, check all outputs against the model, then advance the model.
    task automatic applyStimulus(input logic rst, input logic [3:0] st, input logic iotv,
                                 input logic [11:0] mbv, input logic [5:0] sel,
                                 input logic [7:0] di, input logic [7:0] ds, input logic [7:0] dk,
                                 input logic ackv, input logic [11:0] acv);
        logic [7:0]  pend;
        bit          anyp, win, osel, oskip;
        logic [2:0]  fn;
        logic [11:0] edata;
        int          k;
        @(posedge clk);
        #1;
        reset = rst; state = st; iot = iotv; mb = mbv; io_select = sel;
        dev_interrupt = di; dev_selected = ds; dev_skip = dk; int_ack = ackv; ac = acv;
        #3;
        if (!rst) begin
            modelReset();
            checkOutput("rst_sel", {11'd0, io_selected}, 12'd0);
            checkOutput("rst_skip", {11'd0, io_skip}, 12'd0);
            checkOutput("rst_data", io_data_out, 12'd0);
            checkOutput("rst_req", {11'd0, interrupt_req}, 12'd0);
            checkOutput("rst_ion", {11'd0, ion}, 12'd0);
            checkOutput("rst_src", {8'd0, int_src}, 12'd0);
        end else begin
            pend  = di & m_mask;
            anyp  = (pend != 8'd0);
            win   = (st == 4'd1) && iotv && (sel == 6'd0);
            fn    = mbv[2:0];
            osel  = win && ((fn < 3'd4) || (MASKEN && (fn == 3'd4 || fn == 3'd5)));
            oskip = win && ((fn == 3'd0 && m_ion) || (fn == 3'd3 && anyp));
            edata = (MASKEN && win && fn == 3'd4) ? {4'd0, m_mask} : 12'd0;
            k = 0;
            while (k < NDEV && !pend[k]) k++;
            if (k == NDEV) k = 0;
            checkOutput("sel", {11'd0, io_selected}, {11'd0, osel || (ds != 8'd0)});
            checkOutput("skip", {11'd0, io_skip}, {11'd0, oskip || ((dk & ds) != 8'd0)});
            checkOutput("data", io_data_out, edata);
            checkOutput("req", {11'd0, interrupt_req}, {11'd0, m_ion && (m_left == 0) && anyp});
            checkOutput("ion", {11'd0, ion}, {11'd0, m_ion});
            checkOutput("src", {8'd0, int_src}, k[11:0]);
            if (win) begin
                case (fn)
                    3'd0, 3'd2: begin m_ion = 1'b0; m_left = 0; end
                    3'd1:       begin m_ion = 1'b1; m_left = 2; end
                    3'd5:       if (MASKEN) m_mask = acv[7:0];
                    default: ;
                endcase
            end
            if (st == 4'd3 && m_left > 0) m_left--;
            if (ackv) begin m_ion = 1'b0; m_left = 0; end
        end
    endtask

    task automatic runInstr(input logic [5:0] sel, input logic [11:0] mbv, input logic [7:0] di,
                            input logic [7:0] ds, input logic [7:0] dk, input logic [11:0] acv);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, s[3:0], 1'b1, mbv, sel, di, ds, dk, 1'b0, acv);
            if (s == 1) begin
                f1_skip = io_skip;
                f1_sel  = io_selected;
                f1_data = io_data_out;
            end
        end
    endtask

    initial begin
        logic [7:0]  di, ds, dk;
        logic [5:0]  sel;
        logic [11:0] mbv;
        logic        iotv, rst;
        modelReset();
        reset = 1'b1;
        #2 reset = 1'b0;

        applyStimulus(1'b0, 4'd0, 1'b0, 12'd0, 6'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 12'd0);
        checkOutput("reset_req", {11'd0, interrupt_req}, 12'd0);
        checkOutput("reset_ion", {11'd0, ion}, 12'd0);

        runInstr(6'o00, 12'o6003, 8'hFF, 8'h00, 8'h00, 12'd0);
        checkOutput("srq_skip", {11'd0, f1_skip}, 12'd1);
        checkOutput("srq_sel", {11'd0, f1_sel}, 12'd1);

        runInstr(6'o00, 12'o6001, 8'h08, 8'h00, 8'h00, 12'd0);
        checkOutput("ion_f3_req", {11'd0, interrupt_req}, 12'd0);
        runInstr(6'o10, 12'o6101, 8'h08, 8'h00, 8'h00, 12'd0);
        checkOutput("next_f3_req", {11'd0, interrupt_req}, 12'd0);
        applyStimulus(1'b1, 4'd0, 1'b0, 12'd0, 6'd0, 8'h08, 8'h00, 8'h00, 1'b0, 12'd0);
        checkOutput("f0_req", {11'd0, interrupt_req}, 12'd1);
        checkOutput("f0_src", {8'd0, int_src}, 12'd3);
        applyStimulus(1'b1, 4'd1, 1'b0, 12'd0, 6'd0, 8'h24, 8'h00, 8'h00, 1'b0, 12'd0);
        checkOutput("prio_src", {8'd0, int_src}, 12'd2);
        applyStimulus(1'b1, 4'd2, 1'b0, 12'd0, 6'd0, 8'h24, 8'h00, 8'h00, 1'b1, 12'd0);
        applyStimulus(1'b1, 4'd3, 1'b0, 12'd0, 6'd0, 8'h24, 8'h00, 8'h00, 1'b0, 12'd0);
        checkOutput("ack_ion", {11'd0, ion}, 12'd0);
        checkOutput("ack_req", {11'd0, interrupt_req}, 12'd0);

        runInstr(6'o00, 12'o6001, 8'h00, 8'h00, 8'h00, 12'd0);
        runInstr(6'o00, 12'o6000, 8'h00, 8'h00, 8'h00, 12'd0);
        checkOutput("skon_skip", {11'd0, f1_skip}, 12'd1);
        checkOutput("skon_ion", {11'd0, ion}, 12'd0);
        runInstr(6'o00, 12'o6000, 8'h00, 8'h00, 8'h00, 12'd0);
        checkOutput("skon2_skip", {11'd0, f1_skip}, 12'd0);

        runInstr(6'o03, 12'o6031, 8'h00, 8'h02, 8'h12, 12'd0);
        checkOutput("dev_skip", {11'd0, f1_skip}, 12'd1);
        checkOutput("dev_sel", {11'd0, f1_sel}, 12'd1);
        runInstr(6'o03, 12'o6031, 8'h00, 8'h02, 8'h10, 12'd0);
        checkOutput("dev_noskip", {11'd0, f1_skip}, 12'd0);

        runInstr(6'o00, 12'o6005, 8'h00, 8'h00, 8'h00, 12'o0004);
        runInstr(6'o00, 12'o6001, 8'h05, 8'h00, 8'h00, 12'd0);
        runInstr(6'o10, 12'o6101, 8'h05, 8'h00, 8'h00, 12'd0);
        runInstr(6'o10, 12'o6101, 8'h05, 8'h00, 8'h00, 12'd0);
        checkOutput("mask_src", {8'd0, int_src}, MASKEN ? 12'd2 : 12'd0);
        checkOutput("mask_req", {11'd0, interrupt_req}, 12'd1);
        runInstr(6'o00, 12'o6004, 8'h05, 8'h00, 8'h00, 12'd0);
        checkOutput("mask_read", f1_data, MASKEN ? 12'o0004 : 12'd0);

        for (int n = 0; n < 400; n++) begin
            iotv = ($urandom % 4) != 0;
            sel  = ($urandom % 4 == 0) ? 6'($urandom) : 6'd0;
            mbv  = {3'o6, sel, 3'($urandom)};
            ds   = ($urandom % 3 == 0) ? 8'(1 << ($urandom % 8)) : 8'h00;
            dk   = 8'($urandom);
            for (int s = 0; s < 4; s++) begin
                di  = ($urandom % 2 == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
                rst = ($urandom % 150) != 0;
                applyStimulus(rst, s[3:0], iotv, mbv, sel, di, ds, dk,
                              ($urandom % 12) == 0, 12'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pdp8_intctl.md
Name: pdp8_intctl

Overview:
- Interrupt and IOT-skip controller for the PDP-8 I/O bus, sitting between the CPU and all peripherals (KW8/I clock, TTY, disk, ...).
- Merges per-device interrupt, selected and skip lines, owns the CPU interrupt-enable state, and presents a single interrupt request to the CPU.
- Decodes device-00 IOTs (SKON, ION, IOF, SRQ), including the PDP-8 one-instruction ION delay.
- Reports a priority-encoded interrupt source.

Parameters:
NDEV, 8, number of device interrupt inputs (1..12); index 0 is the highest priority.
IDX_W, 4, width of int_src; must satisfy 2**IDX_W >= NDEV.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
state  input  4  CPU major state (F0=0, F1=1, F2=2, F3=3); each state lasts exactly one clk
iot  input  1  current instruction is an IOT
mb  input  12  memory buffer; mb[2:0] is the IOT function
io_select  input  6  IOT device code
ac  input  12  accumulator (used only with the optional feature)
dev_interrupt  input  NDEV  per-device interrupt request, level
dev_selected  input  NDEV  per-device io_selected
dev_skip  input  NDEV  per-device io_skip
int_ack  input  1  one-clk pulse when the CPU takes the interrupt
io_selected  output  1  merged selected line to the CPU
io_skip  output  1  merged skip line to the CPU
io_data_out  output  12  data returned to AC for device-00 reads
interrupt_req  output  1  interrupt request to the CPU
ion  output  1  interrupt-enable flip-flop
int_src  output  IDX_W  index of the highest-priority pending, unmasked device

Behaviour:
- Reset (reset=0, async): ion=0, ion_delay=0, delay count=0, mask=all ones. All outputs are 0 while in reset.
- Masked request: pend = dev_interrupt & mask; any = |pend.
- Combinational outputs:
  - interrupt_req = ion & ~ion_delay & any.
  - int_src = lowest set index of pend; 0 when pend=0.
- Own decode: active only when state==F1, iot=1 and io_select==6'o00.
  - own_sel=1 for mb[2:0] in {0,1,2,3}, plus {4,5} when the optional feature is compiled in.
  - io_selected = own_sel | (|dev_selected).
  - io_skip = own_skip | (|(dev_skip & dev_selected)).
  - Outside that F1/IOT-00 window, own_sel=0 and own_skip=0.
- Device-00 functions, registered at the F1 clk edge:
  - 0 SKON: own_skip = ion; then ion<=0, ion_delay<=0.
  - 1 ION: ion<=1, ion_delay<=1, delay count<=0.
  - 2 IOF: ion<=0, ion_delay<=0.
  - 3 SRQ: own_skip = any; no state change.
  - 6, 7: not selected, no effect.
- ION delay: while ion_delay=1, count increments on each F3 cycle. ion_delay clears on the second F3 after the ION (the ION's own F3 plus the following instruction's F3). The request therefore becomes visible from the next F0 onward.
- int_ack=1: ion<=0, ion_delay<=0 on that edge. int_ack beats a same-cycle ION.
- ION while ion=1 already: restarts the delay.
- io_data_out = 0 except for the optional-feature read.
- dev_interrupt is level-sensitive. It is never latched here; devices hold their flags until cleared by their own IOTs.
- Reset deasserting mid-instruction: the block resumes with ion=0. No partial IOT effect survives reset.

Optional Feature:
INTCTL_MASK_EN
- Defined:
  - Adds an NDEV-bit mask register.
  - IOT 6005 (mb[2:0]=5) at F1 loads mask<=ac[NDEV-1:0].
  - IOT 6004 (mb[2:0]=4) drives io_data_out = zero-extended mask during that F1 cycle; the CPU ORs it into AC.
  - Both functions assert io_selected.
- Undefined:
  - Mask is constant all ones.
  - Functions 4 and 5 are unselected and have no effect.
  - io_data_out is constantly 0.

Test Plan:
- Reset=0 with dev_interrupt=8'hFF -> interrupt_req=0, ion=0, io_skip=0. Release reset; SRQ (io_select=0, mb=6003 at F1) -> io_skip=1, io_selected=1.
- ION at F1, dev_interrupt[3]=1 -> interrupt_req stays 0 through the ION's F3 and the next instruction's F3, rises in the following F0; int_src=3.
- dev_interrupt=8'b0010_0100 with ion=1 settled -> int_src=2. Pulse int_ack -> ion=0 and interrupt_req=0 next cycle.
- SKON with ion=1 -> io_skip=1 in F1, ion=0 after. Repeat SKON -> io_skip=0.
- dev_selected[1]=1, dev_skip[1]=1, dev_skip[4]=1 (dev_selected[4]=0) at F1 -> io_skip=1, io_selected=1. With dev_skip[1]=0 -> io_skip=0.
- INTCTL_MASK_EN: ac=12'o0004, IOT 6005 -> mask=8'h04. dev_interrupt=8'h05 with ion settled -> int_src=2. IOT 6004 -> io_data_out=12'o0004.
